// File: rtl/fifo_pkg.sv
// Gray-code helpers shared by the async FIFO and its synchronisers.
// Zero-extended operands keep both conversions width-generic up to GRAY_MAX_W bits.
package fifo_pkg;
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its gray bit and every higher gray bit.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer entering another clock domain.
module gray_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock gray-pointer FIFO with fill levels, almost flags, sticky errors
// and a registered read port.
module async_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 2
) (
    input  logic              write_clk,
    input  logic              write_reset_n,
    input  logic              read_clk,
    input  logic              read_reset_n,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic              wr_clear_err,
    output logic              write_full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow,
    input  logic              read_enable,
    input  logic              rd_clear_err,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              read_empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_sync, rbin_sync, wr_level_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_sync, wbin_sync, rd_level_next;
    logic          write_accept, read_accept, full_next, empty_next;

    gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rgray_sync (
        .clk(write_clk), .reset_n(write_reset_n), .d(rgray), .q(rgray_sync)
    );
    gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wgray_sync (
        .clk(read_clk), .reset_n(read_reset_n), .d(wgray), .q(wgray_sync)
    );

    // Write domain
    assign write_accept  = write_enable & ~write_full;
    assign wbin_next     = wbin + PW'(write_accept);
    assign wgray_next    = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
    assign rbin_sync     = PW'(gray2bin(GRAY_MAX_W'(rgray_sync)));
    assign wr_level_next = wbin_next - rbin_sync;
    // Full when the write pointer has lapped the read pointer by exactly DEPTH.
    assign full_next     = wgray_next == {~rgray_sync[PW-1 -: 2], rgray_sync[PW-3:0]};

    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            wbin        <= '0;
            wgray       <= '0;
            write_full  <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            write_full  <= full_next;
            almost_full <= wr_level_next >= PW'(DEPTH - AF_MARGIN);
            wr_level    <= wr_level_next;
            overflow    <= (overflow & ~wr_clear_err) | (write_enable & write_full);
        end
    end

    always_ff @(posedge write_clk) begin
        if (write_accept) mem[wbin[ADDR_W-1:0]] <= write_data;
    end

    // Read domain
    assign read_accept   = read_enable & ~read_empty;
    assign rbin_next     = rbin + PW'(read_accept);
    assign rgray_next    = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
    assign wbin_sync     = PW'(gray2bin(GRAY_MAX_W'(wgray_sync)));
    assign rd_level_next = wbin_sync - rbin_next;
    assign empty_next    = rgray_next == wgray_sync;

    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            rbin         <= '0;
            rgray        <= '0;
            read_empty   <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            read_data    <= '0;
            read_valid   <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            read_empty   <= empty_next;
            almost_empty <= rd_level_next <= PW'(AE_MARGIN);
            rd_level     <= rd_level_next;
            read_valid   <= read_accept;
            underflow    <= (underflow & ~rd_clear_err) | (read_enable & read_empty);
            if (read_accept) read_data <= mem[rbin[ADDR_W-1:0]];
        end
    end
endmodule
